// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, arbiter state enum and burst-length lookup
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_BURST  = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_e;

    localparam int CNT_W = 4;

    // 0 marks an undefined-length (INCR) burst.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HB_SINGLE:           burst_beats = 5'd1;
            HB_INCR:             burst_beats = 5'd0;
            HB_WRAP4, HB_INCR4:  burst_beats = 5'd4;
            HB_WRAP8, HB_INCR8:  burst_beats = 5'd8;
            default:             burst_beats = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin picker starting at ptr_i
module ahb_rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    localparam logic [IW:0] N_V = (IW+1)'(N);

    always_comb begin : pick
        logic [IW:0] pos;
        pos     = '0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(i);
            if (pos >= N_V) begin
                pos = pos - N_V;
            end
            if (!valid_o && req_i[pos[IW-1:0]]) begin
                valid_o               = 1'b1;
                grant_o[pos[IW-1:0]]  = 1'b1;
                idx_o                 = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB bus arbiter with burst and locked-transfer handling
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int IW             = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [IW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [IW-1:0]          DEF_IDX   = IW'(DEFAULT_MASTER);
    localparam logic [IW-1:0]          LAST_IDX  = IW'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [IW-1:0]          master_q, master_d;
    logic                   mlock_q, mlock_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic [IW-1:0]          rr_start;
    logic [4:0]             beats;
    logic                   fixed_burst;
    logic                   arb_ok;

    assign rr_start    = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;
    assign beats       = burst_beats(hburst);
    assign fixed_burst = (beats > 5'd1);

    // A locked owner only releases the bus by dropping hlock; otherwise the
    // bus is re-arbitrated between transfers or on the last beat of a fixed burst.
    assign arb_ok = hready && ((state_q == ST_LOCKED) ? !hlock[gidx_q] :
                    (htrans == HT_IDLE) || !fixed_burst ||
                    (htrans == HT_SEQ && cnt_q == CNT_W'(1)));

    ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req_i   (hbusreq),
        .ptr_i   (rr_start),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        master_d = master_q;
        mlock_d  = mlock_q;
        cnt_d    = cnt_q;
        if (hready) begin
            master_d = gidx_q;
            mlock_d  = hlock[gidx_q];
            if (htrans == HT_NONSEQ) begin
                cnt_d = fixed_burst ? CNT_W'(beats - 5'd1) : '0;
            end else if (htrans == HT_SEQ && cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (arb_ok) begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
                    rr_d    = pick_idx;
                    state_d = hlock[pick_idx] ? ST_LOCKED : ST_OWNED;
                end else begin
                    grant_d = DEF_GRANT;
                    gidx_d  = DEF_IDX;
                    state_d = ST_PARK;
                end
            end else if (state_q != ST_LOCKED && htrans == HT_NONSEQ && fixed_burst) begin
                state_d = ST_BURST;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_PARK;
            grant_q  <= DEF_GRANT;
            gidx_q   <= DEF_IDX;
            rr_q     <= DEF_IDX;
            master_q <= DEF_IDX;
            mlock_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            master_q <= master_d;
            mlock_q  <= mlock_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = master_q;
    assign hmastlock = mlock_q;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters (2..8).
REQ-002 Parameter DEFAULT_MASTER, default 0: master parked on the bus when nobody requests.
REQ-003 hclk  input  1  bus clock; all state on rising edge.
REQ-004 hresetn  input  1  reset, asynchronous, active-low.
REQ-005 hbusreq  input  NUM_MASTERS  per-master bus request.
REQ-006 hlock  input  NUM_MASTERS  per-master locked-transfer request.
REQ-007 htrans  input  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 hburst  input  3  burst type of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
REQ-009 hready  input  1  bus ready from the selected slave.
REQ-010 hgrant  output  NUM_MASTERS  one-hot grant, registered.
REQ-011 hmaster  output  $clog2(NUM_MASTERS)  index of the address-phase owner, registered.
REQ-012 hmastlock  output  1  current address phase is locked, registered.

Function
REQ-013 hgrant shall be exactly one-hot in every cycle after reset.
REQ-014 State machine states: PARK (default master, no requests), OWNED (single or INCR burst), BURST (fixed-length burst), LOCKED.
REQ-015 Arbitration point: hready=1 and state!=LOCKED and (htrans==IDLE, or hburst in {SINGLE,INCR}, or htrans==SEQ with beat counter==1, or htrans==NONSEQ of a fixed-length burst only when that burst length is 1).
REQ-016 At an arbitration point the winner is the first requesting master in round-robin order starting at (last winner + 1) mod NUM_MASTERS; hgrant updates on that edge.
REQ-017 No hbusreq bits set at an arbitration point: hgrant goes to DEFAULT_MASTER, state PARK.
REQ-018 Beat counter: on hready=1 and htrans==NONSEQ load 3/7/15 for 4/8/16-beat bursts (state BURST); on hready=1 and htrans==SEQ decrement; BUSY and hready=0 hold it.
REQ-019 BURST returns to OWNED/PARK at the arbitration point where counter==1; the counter reaching 0 never wraps.
REQ-020 hready=0: hgrant, hmaster, hmastlock, counter and state all hold.
REQ-021 hmaster and hmastlock update only when hready=1, taking the grant index and hlock[granted] that were valid before the edge (one hready-cycle behind hgrant).
REQ-022 LOCKED entered when the granted master has hlock=1 at an arbitration point; grant held while hlock[owner]=1; exit at the first hready=1 edge with hlock[owner]=0, which is also an arbitration point.
REQ-023 A granted master dropping hbusreq mid fixed burst shall not lose grant before counter reaches 1.
REQ-024 The round-robin pointer advances only when a requesting master wins; parking does not move it.
REQ-025 Simultaneous new request and hlock from the same master: grant and lock take effect on the same edge.

Reset
REQ-026 While hresetn=0: hgrant=1<<DEFAULT_MASTER, hmaster=DEFAULT_MASTER, hmastlock=0, counter=0, state PARK, rr pointer=DEFAULT_MASTER.
REQ-027 Reset asserted mid-burst or mid-lock clears all state immediately, with no completion of the burst.
REQ-028 First arbitration after reset release occurs at the first rising edge with hready=1.

Structure
REQ-029 htrans/hburst encodings, burst-length lookup and the state enum shall live in the shared package ahb_pkg.
REQ-030 Round-robin selection shall be a combinational sub-module ahb_rr_picker (inputs: request vector, pointer; outputs: one-hot winner, index, any-valid).
REQ-031 Bench shall reuse the existing AHB master model and slave, instantiate 4 masters and run under the smoke-test framework.

Verification
REQ-032 Masters 1,2,3 request together, SINGLE transfers, hready=1 -> grants 1,2,3,1 on successive arbitration points; hmaster lags hgrant by one cycle.
REQ-033 Master 2 issues INCR8 while master 0 requests -> hgrant stays 0b0100 for 7 SEQ beats and switches to 0b0001 on the edge where counter==1.
REQ-034 Master 1 locked with hlock=1 for 3 transfers while master 3 requests -> hmastlock=1 throughout, grant moves to master 3 only after hlock drops.
REQ-035 hready=0 for 5 cycles mid INCR4 -> hgrant, hmaster, counter unchanged; burst completes after hready returns.
REQ-036 All hbusreq=0 -> hgrant=0b0001 (DEFAULT_MASTER=0), state PARK.
REQ-037 hresetn pulsed low during WRAP16 beat 6 -> outputs return to reset values asynchronously, counter=0.
